// File: rtl/psum_feeder_if.sv
// Bundles the PE-array write port and the partial-sum stream to the aggregator.
// The psum_par signal exists only when PSUM_PARITY_EN is defined.
interface psum_feeder_if #(
  parameter int unsigned agg_width = 12
);
  logic                 wr_en;
  logic [agg_width-1:0] wr_data;
  logic                 wr_last;
  logic                 wr_full;
  logic                 agg_ready;
  logic [agg_width-1:0] psum_out;
  logic                 psum_valid;
  logic                 psum_last;
`ifdef PSUM_PARITY_EN
  logic                 psum_par;

  modport master (
    input  wr_en, wr_data, wr_last, agg_ready,
    output wr_full, psum_out, psum_valid, psum_last, psum_par
  );
  modport slave (
    output wr_en, wr_data, wr_last, agg_ready,
    input  wr_full, psum_out, psum_valid, psum_last, psum_par
  );
`else
  modport master (
    input  wr_en, wr_data, wr_last, agg_ready,
    output wr_full, psum_out, psum_valid, psum_last
  );
  modport slave (
    output wr_en, wr_data, wr_last, agg_ready,
    input  wr_full, psum_out, psum_valid, psum_last
  );
`endif
endinterface

// File: rtl/psum_feeder.sv
// FIFO-buffered partial-sum feeder: streams framed words to the aggregator with a
// programmable idle gap after each frame. Optional parity output under PSUM_PARITY_EN.
module psum_feeder #(
  parameter int unsigned agg_width  = 12,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  psum_feeder_if.master     bus,
  output logic [7:0]        frame_cnt,
  output logic              overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef struct packed {
    logic                 last;
    logic [agg_width-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  entry_t               mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q;
  logic                 ovf_q;
  state_t               state_q, state_d;
  logic [agg_width-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [7:0]           frame_q, frame_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 pop;
  logic                 accept;
  logic                 empty;
  entry_t               head;

  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign accept  = bus.wr_en && !full_q;
  assign count_d = count_q + CW'(accept) - CW'(pop);

  // Storage array carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= '{last: bus.wr_last, data: bus.wr_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      if (bus.wr_en && full_q) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      frame_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      frame_q <= frame_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state: output register loads straight from the FIFO head on each pop.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    valid_d = valid_q;
    last_d  = last_q;
    frame_d = frame_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          out_d   = head.data;
          last_d  = head.last;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (valid_q) begin
          if (bus.agg_ready) begin
            if (last_q) begin
              frame_d = frame_q + 8'd1;
              valid_d = 1'b0;
              last_d  = 1'b0;
              gap_d   = GW'(GAP_CYCLES);
              state_d = GAP;
            end else if (!empty) begin
              pop    = 1'b1;
              out_d  = head.data;
              last_d = head.last;
            end else begin
              valid_d = 1'b0;
            end
          end
        end else if (!empty) begin
          // Recover from a mid-frame underrun.
          pop     = 1'b1;
          out_d   = head.data;
          last_d  = head.last;
          valid_d = 1'b1;
        end
      end
      GAP: begin
        valid_d = 1'b0;
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PSUM_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= ^out_d;
  end

  assign bus.psum_par = par_q;
`endif

  assign bus.psum_out   = out_q;
  assign bus.psum_valid = valid_q;
  assign bus.psum_last  = last_q;
  assign bus.wr_full    = full_q;
  assign frame_cnt      = frame_q;
  assign overflow       = ovf_q;

endmodule
